// File: rtl/cpu_debug_ocimem_pkg.sv
// Shared constants and types for the OCI debug-memory controller.
package cpu_debug_ocimem_pkg;

    // Bit positions inside the 38-bit JTAG data-out word
    localparam int JDO_W         = 38;
    localparam int JDO_RD        = 35;
    localparam int JDO_CLRERR    = 25;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;

    // Controller sequencing: idle, JTAG read in flight, CPU read in flight
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        J_RD = 2'd1,
        C_RD = 2'd2
    } state_e;

    // Kind of JTAG operation waiting for the RAM
    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/cpu_debug_ocimem_ram.sv
// Single-port 32-bit debug RAM with byte enables and a registered read port.
module cpu_debug_ocimem_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       q_o
);

    logic [31:0] mem [2**ADDR_W];

    // Byte-masked write and registered read; a read of the written word returns old data
    // NOTE: the storage array has no reset; clearing it would need a per-word reset network.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        q_o <= mem[addr_i];
    end

endmodule

// File: rtl/cpu_debug_ocimem_ctrl.sv
// OCI debug-memory controller: JTAG-driven reads/writes of the debug RAM,
// plus the CPU's Avalon debug-memory slave port. JTAG wins the RAM.
module cpu_debug_ocimem_ctrl
    import cpu_debug_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    input  logic              debugaccess,
    output logic [31:0]       readdata,
    output logic              waitrequest
);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
    logic [31:0]         mon_d_q, mon_d_d;
    logic                ready_q, ready_d;
    logic                error_q, error_d;

    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_we;
    logic [3:0]          ram_be;
    logic [31:0]         ram_wdata;
    logic [31:0]         ram_q;
    logic                cpu_done;
    logic                any_strobe;

    // jdo bits that carry no meaning for this block
    logic unused_jdo;
    assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD+1], jdo[JDO_WDATA_LSB-1:0]};

    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

    // Strobe decode, overrun detection, RAM arbitration and sequencing
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d   = state_q;
        op_d      = op_q;
        pend_d    = pend_q;
        mon_a_d   = mon_a_q;
        mon_d_d   = mon_d_q;
        ready_d   = ready_q;
        error_d   = error_q;
        ram_addr  = address;
        ram_we    = 1'b0;
        ram_be    = byteenable;
        ram_wdata = writedata;
        cpu_done  = 1'b0;
        readdata  = '0;

        // A JTAG op still owns the slot: flag the overrun and drop the strobe
        if (any_strobe && pend_q) begin
            error_d = 1'b1;
        end else if (take_action_ocimem_a) begin
            mon_a_d = jdo[JDO_ADDR_LSB +: ADDR_W];
            if (jdo[JDO_CLRERR]) error_d = 1'b0;
            if (jdo[JDO_RD]) begin
                pend_d  = 1'b1;
                op_d    = OP_RD;
                ready_d = 1'b0;
            end
        end else if (take_no_action_ocimem_a) begin
            if (jdo[JDO_RD]) begin
                pend_d  = 1'b1;
                op_d    = OP_RD;
                ready_d = 1'b0;
            end
        end else if (take_action_ocimem_b) begin
            mon_d_d = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
            pend_d  = 1'b1;
            op_d    = OP_WR;
            ready_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    ram_addr = mon_a_q;
                    if (op_q == OP_RD) begin
                        state_d = J_RD;
                    end else begin
                        ram_we    = 1'b1;
                        ram_be    = 4'hF;
                        ram_wdata = mon_d_q;
                        mon_a_d   = mon_a_q + ADDR_W'(1);
                        ready_d   = 1'b1;
                        pend_d    = 1'b0;
                    end
                end else if (read) begin
                    state_d = C_RD;
                end else if (write) begin
                    // Writes without debugaccess are acknowledged but never reach the RAM
                    ram_we   = debugaccess;
                    cpu_done = 1'b1;
                end
            end
            J_RD: begin
                mon_d_d = ram_q;
                mon_a_d = mon_a_q + ADDR_W'(1);
                ready_d = 1'b1;
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            C_RD: begin
                readdata = ram_q;
                cpu_done = read;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign waitrequest   = (read | write) & ~cpu_done;
    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

    // Controller state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            pend_q  <= 1'b0;
            mon_a_q <= '0;
            mon_d_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            op_q    <= op_d;
            pend_q  <= pend_d;
            mon_a_q <= mon_a_d;
            mon_d_q <= mon_d_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    cpu_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .q_o     (ram_q)
    );

endmodule

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// Self-checking bench for cpu_debug_ocimem_ctrl: directed vector table,
// multi-cycle corner sequences, and a randomized run against a
// transaction-level memory model.
module tb_cpu_debug_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        ta_a, tna_a, ta_b;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic [7:0]  address;
    logic        read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        debugaccess;
    logic [31:0] readdata;
    logic        waitrequest;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: memory contents and the JTAG address pointer
    logic [31:0] model_mem [256];
    logic [7:0]  model_mona;

    always #5 clk = ~clk;

    cpu_debug_ocimem_ctrl #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_no_action_ocimem_a (tna_a),
        .take_action_ocimem_b    (ta_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .address                 (address),
        .read                    (read),
        .write                   (write),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .debugaccess             (debugaccess),
        .readdata                (readdata),
        .waitrequest             (waitrequest)
    );

    typedef enum {V_JWR, V_JRD, V_NRD, V_CWR, V_CRD} vkind_e;
    typedef struct {
        vkind_e      kind;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        dbg;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [37:0] jdo_a(input logic rd, input logic clr, input logic [7:0] a);
        logic [37:0] j;
        j = '0; j[35] = rd; j[25] = clr; j[24:17] = a;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0; j[34:3] = d;
        return j;
    endfunction

    function automatic logic [37:0] jdo_rd();
        logic [37:0] j;
        j = '0; j[35] = 1'b1;
        return j;
    endfunction

    function automatic vec_t mkv(input vkind_e k, input logic [7:0] a, input logic [31:0] d,
                                 input logic [3:0] be, input logic dbg,
                                 input logic [31:0] e, input int lat);
        vec_t v;
        v.kind = k; v.addr = a; v.data = d; v.be = be; v.dbg = dbg;
        v.exp_data = e; v.exp_lat = lat;
        return v;
    endfunction

    // One-cycle strobe; returns at the negedge of the following cycle
    task automatic strobe(input int which, input logic [37:0] j);
        @(negedge clk);
        jdo = j; ta_a = (which == 0); tna_a = (which == 1); ta_b = (which == 2);
        @(negedge clk);
        ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
    endtask

    // Cycles from strobe to monitor_ready, bounded
    task automatic wait_ready(output int lat);
        lat = 1;
        while (!monitor_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic jtag_write(input logic [7:0] a, input logic [31:0] d, output int lat);
        strobe(0, jdo_a(1'b0, 1'b0, a));
        strobe(2, jdo_b(d));
        wait_ready(lat);
        model_mem[a] = d;
        model_mona   = a + 8'd1;
    endtask

    task automatic jtag_read(input logic [7:0] a, output logic [31:0] d, output int lat);
        strobe(0, jdo_a(1'b1, 1'b0, a));
        wait_ready(lat);
        d = MonDReg;
        model_mona = a + 8'd1;
    endtask

    task automatic jtag_read_cur(output logic [31:0] d, output int lat, output logic [7:0] from);
        from = model_mona;
        strobe(1, jdo_rd());
        wait_ready(lat);
        d = MonDReg;
        model_mona = from + 8'd1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                             input logic dbg, output logic w);
        @(negedge clk);
        address = a; writedata = d; byteenable = be; debugaccess = dbg; write = 1'b1;
        #1 w = waitrequest;
        @(negedge clk);
        write = 1'b0;
        if (dbg) model_mem[a] = merge(model_mem[a], d, be);
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int waits);
        @(negedge clk);
        address = a; read = 1'b1; waits = 0;
        #1;
        while (waitrequest && waits < 10) begin
            waits++;
            @(negedge clk);
            #1;
        end
        d = readdata;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic zero_ram();
        logic w;
        for (int i = 0; i < 256; i++) cpu_write(8'(i), 32'h0, 4'hF, 1'b1, w);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_MonDReg"}, MonDReg, 32'h0);
        check({tag, "_ready"}, 32'(monitor_ready), 32'h0);
        check({tag, "_error"}, 32'(monitor_error), 32'h0);
        check({tag, "_readdata"}, readdata, 32'h0);
        check({tag, "_wait"}, 32'(waitrequest), 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  from;
        logic        w;
        int          lat, waits;

        reset_n = 1'b0; jdo = '0; ta_a = 0; tna_a = 0; ta_b = 0;
        address = '0; read = 0; write = 0; writedata = '0; byteenable = '0; debugaccess = 0;
        model_mona = 8'h00;
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;

        repeat (3) @(negedge clk);
        #1 check_reset_outputs("rst_hold");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1 check_reset_outputs("rst_rel");

        zero_ram();

        // ---------------- directed vector table ----------------
        vecs.push_back(mkv(V_JWR, 8'h00, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0, 2));
        vecs.push_back(mkv(V_JWR, 8'h11, 32'h0BADC0DE, 4'hF, 1'b1, 32'h0, 2));
        vecs.push_back(mkv(V_JWR, 8'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, 2));
        vecs.push_back(mkv(V_NRD, 8'h00, 32'h0,        4'hF, 1'b1, 32'h0BADC0DE, 3));
        vecs.push_back(mkv(V_JRD, 8'h10, 32'h0,        4'hF, 1'b1, 32'hDEADBEEF, 3));
        vecs.push_back(mkv(V_NRD, 8'h00, 32'h0,        4'hF, 1'b1, 32'h0BADC0DE, 3));
        vecs.push_back(mkv(V_JWR, 8'hFF, 32'h12345678, 4'hF, 1'b1, 32'h0, 2));
        vecs.push_back(mkv(V_NRD, 8'h00, 32'h0,        4'hF, 1'b1, 32'hCAFEF00D, 3));
        vecs.push_back(mkv(V_JRD, 8'hFF, 32'h0,        4'hF, 1'b1, 32'h12345678, 3));
        vecs.push_back(mkv(V_NRD, 8'h00, 32'h0,        4'hF, 1'b1, 32'hCAFEF00D, 3));
        vecs.push_back(mkv(V_CWR, 8'h20, 32'hAAAA5555, 4'b0011, 1'b1, 32'h0, 0));
        vecs.push_back(mkv(V_CRD, 8'h20, 32'h0,        4'hF, 1'b1, 32'h00005555, 1));
        vecs.push_back(mkv(V_CWR, 8'h20, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 0));
        vecs.push_back(mkv(V_CRD, 8'h20, 32'h0,        4'hF, 1'b1, 32'h00005555, 1));
        vecs.push_back(mkv(V_CWR, 8'h21, 32'h11223344, 4'b1100, 1'b1, 32'h0, 0));
        vecs.push_back(mkv(V_CRD, 8'h21, 32'h0,        4'hF, 1'b1, 32'h11220000, 1));
        vecs.push_back(mkv(V_CRD, 8'h10, 32'h0,        4'hF, 1'b1, 32'hDEADBEEF, 1));
        vecs.push_back(mkv(V_CRD, 8'hFF, 32'h0,        4'hF, 1'b1, 32'h12345678, 1));
        vecs.push_back(mkv(V_JRD, 8'h21, 32'h0,        4'hF, 1'b1, 32'h11220000, 3));

        foreach (vecs[i]) begin
            case (vecs[i].kind)
                V_JWR: begin
                    jtag_write(vecs[i].addr, vecs[i].data, lat);
                    check($sformatf("vec%0d_jwr_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
                end
                V_JRD: begin
                    jtag_read(vecs[i].addr, d, lat);
                    check($sformatf("vec%0d_jrd_data", i), d, vecs[i].exp_data);
                    check($sformatf("vec%0d_jrd_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
                end
                V_NRD: begin
                    jtag_read_cur(d, lat, from);
                    check($sformatf("vec%0d_nrd_data", i), d, vecs[i].exp_data);
                    check($sformatf("vec%0d_nrd_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
                end
                V_CWR: begin
                    cpu_write(vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].dbg, w);
                    check($sformatf("vec%0d_cwr_wait", i), 32'(w), 32'(vecs[i].exp_lat));
                end
                default: begin
                    cpu_read(vecs[i].addr, d, waits);
                    check($sformatf("vec%0d_crd_data", i), d, vecs[i].exp_data);
                    check($sformatf("vec%0d_crd_waits", i), 32'(waits), 32'(vecs[i].exp_lat));
                end
            endcase
        end

        // ---------------- JTAG write pending while CPU reads ----------------
        strobe(0, jdo_a(1'b0, 1'b0, 8'h30));
        @(negedge clk);
        jdo = jdo_b(32'h5A5AA5A5); ta_b = 1'b1;
        @(negedge clk);
        ta_b = 1'b0; address = 8'h10; read = 1'b1; waits = 0;
        #1;
        while (waitrequest && waits < 10) begin
            waits++;
            @(negedge clk);
            #1;
        end
        check("prio_cpu_waits", 32'(waits), 32'd2);
        check("prio_cpu_data", readdata, 32'hDEADBEEF);
        check("prio_jtag_ready", 32'(monitor_ready), 32'd1);
        @(negedge clk);
        read = 1'b0;
        model_mem[8'h30] = 32'h5A5AA5A5;
        model_mona = 8'h31;
        cpu_read(8'h30, d, waits);
        check("prio_jtag_landed", d, 32'h5A5AA5A5);

        // ---------------- overrun: back-to-back ocimem_b ----------------
        strobe(0, jdo_a(1'b0, 1'b0, 8'h40));
        @(negedge clk);
        jdo = jdo_b(32'h11111111); ta_b = 1'b1;
        @(negedge clk);
        jdo = jdo_b(32'h22222222);
        @(negedge clk);
        ta_b = 1'b0;
        check("ovr_error_set", 32'(monitor_error), 32'd1);
        wait_ready(lat);
        check("ovr_MonDReg", MonDReg, 32'h11111111);
        model_mem[8'h40] = 32'h11111111;
        model_mona = 8'h41;
        cpu_read(8'h40, d, waits);
        check("ovr_first_landed", d, 32'h11111111);
        cpu_read(8'h41, d, waits);
        check("ovr_second_dropped", d, 32'h0);

        // Clear request arriving together with an overrun: the overrun wins
        strobe(0, jdo_a(1'b0, 1'b0, 8'h50));
        @(negedge clk);
        jdo = jdo_b(32'h33333333); ta_b = 1'b1;
        @(negedge clk);
        ta_b = 1'b0; jdo = jdo_a(1'b0, 1'b1, 8'h60); ta_a = 1'b1;
        @(negedge clk);
        ta_a = 1'b0;
        check("clr_vs_ovr_error", 32'(monitor_error), 32'd1);
        wait_ready(lat);
        model_mem[8'h50] = 32'h33333333;
        model_mona = 8'h51;
        cpu_read(8'h50, d, waits);
        check("clr_vs_ovr_write", d, 32'h33333333);

        // Standalone clear
        strobe(0, jdo_a(1'b0, 1'b1, 8'h00));
        model_mona = 8'h00;
        check("err_cleared", 32'(monitor_error), 32'd0);

        // ---------------- reset in the middle of a JTAG read ----------------
        @(negedge clk);
        jdo = jdo_a(1'b1, 1'b0, 8'h10); ta_a = 1'b1;
        @(negedge clk);
        ta_a = 1'b0; jdo = jdo_rd(); tna_a = 1'b1; address = 8'h20; read = 1'b1;
        #1 check("jrd_pend_cpu_wait", 32'(waitrequest), 32'd1);
        @(negedge clk);
        tna_a = 1'b0;
        #1;
        check("jrd_busy_cpu_wait", 32'(waitrequest), 32'd1);
        check("jrd_busy_error", 32'(monitor_error), 32'd1);
        check("jrd_busy_ready", 32'(monitor_ready), 32'd0);
        reset_n = 1'b0; read = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("midrst_rel");

        zero_ram();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        model_mona = 8'h00;

        // ---------------- randomized run against the model ----------------
        for (int n = 0; n < 150; n++) begin
            int          k;
            logic [7:0]  a;
            logic [31:0] rd;
            logic [3:0]  be;
            logic        dbg;
            k   = $urandom_range(0, 4);
            a   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'(8'hF8 + $urandom_range(0, 7));
            rd  = $urandom;
            be  = 4'($urandom_range(0, 15));
            dbg = ($urandom_range(0, 3) != 0);
            case (k)
                0: begin
                    jtag_write(a, rd, lat);
                    check($sformatf("rnd%0d_jwr_lat", n), 32'(lat), 32'd2);
                end
                1: begin
                    jtag_read(a, d, lat);
                    check($sformatf("rnd%0d_jrd_data", n), d, model_mem[a]);
                    check($sformatf("rnd%0d_jrd_lat", n), 32'(lat), 32'd3);
                end
                2: begin
                    jtag_read_cur(d, lat, from);
                    check($sformatf("rnd%0d_nrd_data", n), d, model_mem[from]);
                    check($sformatf("rnd%0d_nrd_lat", n), 32'(lat), 32'd3);
                end
                3: begin
                    cpu_write(a, rd, be, dbg, w);
                    check($sformatf("rnd%0d_cwr_wait", n), 32'(w), 32'd0);
                end
                default: begin
                    cpu_read(a, d, waits);
                    check($sformatf("rnd%0d_crd_data", n), d, model_mem[a]);
                    check($sformatf("rnd%0d_crd_waits", n), 32'(waits), 32'd1);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_debug_ocimem_ctrl.md
Name: cpu_debug_ocimem_ctrl

Overview:
On-chip debug memory (OCI RAM) controller directly downstream of the debug slave wrapper's sysclk outputs.
- Consumes jdo and the take_action_ocimem_a / take_no_action_ocimem_a / take_action_ocimem_b strobes to perform JTAG-driven reads and writes of a debug RAM.
- Produces MonDReg, monitor_ready and monitor_error, which feed back into the wrapper's tck scan chain.
- Also serves the CPU's Avalon debug-memory slave port; JTAG has priority over CPU.

Parameters:
ADDR_W, 8, word-address width of debug RAM (depth 2**ADDR_W words of 32 bits)

Ports:
clk  in  1  system clock; single clock domain
reset_n  in  1  asynchronous, active-low reset
jdo  in  38  JTAG data out, from debug slave sysclk stage
take_action_ocimem_a  in  1  one-cycle strobe: load address, optional clear-error/read
take_no_action_ocimem_a  in  1  one-cycle strobe: optional read at current address
take_action_ocimem_b  in  1  one-cycle strobe: write jdo data at current address
MonDReg  out  32  monitor data register (JTAG read result / write data)
monitor_ready  out  1  last JTAG operation complete
monitor_error  out  1  JTAG overrun: strobe arrived while a JTAG op was pending
address  in  ADDR_W  CPU slave word address
read  in  1  CPU read request
write  in  1  CPU write request
writedata  in  32  CPU write data
byteenable  in  4  CPU byte enables
debugaccess  in  1  CPU write permitted only when high
readdata  out  32  CPU read data
waitrequest  out  1  Avalon wait; combinational

Behaviour:
- Reset values (async assert, sync release): MonAReg=0, MonDReg=0, monitor_ready=0, monitor_error=0, jtag pending=0, FSM=IDLE, readdata=0.
- jdo decode:
  - ocimem_a: MonAReg<=jdo[17+ADDR_W-1:17]; jdo[25]=1 clears monitor_error; jdo[35]=1 queues JTAG read at the newly loaded address.
  - no_action_ocimem_a: jdo[35]=1 queues JTAG read at the current MonAReg.
  - ocimem_b: MonDReg<=jdo[34:3]; queues JTAG write (all 4 bytes).
- Queueing:
  - A strobe at cycle T sets pend (with op type) at T+1 and clears monitor_ready.
  - A strobe while pend=1 or an op is in flight: sets monitor_error, the strobe is ignored, existing op unaffected.
  - An error clear (jdo[25]) arriving together with an overrun: set wins.
- FSM states: IDLE, J_RD, C_RD.
  - IDLE, pend=1 (priority):
    - read: drive RAM addr=MonAReg and go J_RD.
    - write: write MonDReg in this cycle, MonAReg+=1 (wraps 2**ADDR_W-1 -> 0), monitor_ready<=1, pend<=0, stay IDLE.
  - IDLE, pend=0, read=1: drive RAM addr=address, waitrequest=1, go C_RD.
  - IDLE, pend=0, write=1: RAM write with byteenable if debugaccess=1, otherwise dropped; waitrequest=0 in the same cycle.
  - J_RD: MonDReg<=RAM q, MonAReg+=1 (wrap), monitor_ready<=1, pend<=0, go IDLE.
  - C_RD: readdata=RAM q (combinational from RAM output), waitrequest=0, go IDLE.
- Latency:
  - CPU read: 2 cycles, waitrequest high for exactly 1.
  - CPU write: 1 cycle when no JTAG op is pending.
  - JTAG read: 3 cycles from strobe to monitor_ready (strobe T, issue T+1, ready visible T+3).
  - JTAG write: 2 cycles from strobe to monitor_ready.
- waitrequest=(read|write) & ~(serviced this cycle); it stays high while JTAG holds the RAM.
- A CPU request already in C_RD completes before pend is serviced.
- RAM is 1-cycle registered-read, single port; read-during-write returns old data (not exercised by the FSM).
- reset_n low mid-operation aborts the op; RAM contents are undefined after reset.

Decomposition:
- Package cpu_debug_ocimem_pkg holds:
  - jdo bit constants: JDO_RD=35, JDO_CLRERR=25, JDO_ADDR_LSB=17, JDO_WDATA_MSB=34, JDO_WDATA_LSB=3.
  - state enum {IDLE, J_RD, C_RD}.
  - op-type enum {OP_RD, OP_WR}.
- One sub-module, cpu_debug_ocimem_ram: 2**ADDR_W x 32 single-port RAM with byte enables and a registered output.

Test Plan:
- ocimem_a with jdo[24:17]=0x10 and jdo[35]=0, then ocimem_b with data 0xDEADBEEF -> RAM[0x10]=0xDEADBEEF, MonAReg=0x11, monitor_ready=1 two cycles after the ocimem_b strobe.
- ocimem_a with addr 0x10 and jdo[35]=1 -> MonDReg=0xDEADBEEF and monitor_ready=1 three cycles after the strobe; MonAReg=0x11.
- Address wrap: ocimem_a addr 0xFF, then ocimem_b 0x12345678 -> RAM[0xFF] written, MonAReg=0x00.
- CPU write with debugaccess=1, byteenable=4'b0011, writedata 0xAAAA5555 to addr 0x20 (RAM pre-zeroed); CPU read of 0x20 -> readdata=0x00005555, waitrequest high exactly 1 cycle.
- Same-cycle JTAG write pend and CPU read -> JTAG serviced first and the CPU waits 1 extra cycle. A CPU write with debugaccess=0 is dropped (RAM unchanged) and completes in 1 cycle.
- Overrun: second ocimem_b strobe 1 cycle after the first -> monitor_error=1 and only the first write lands. A later ocimem_a with jdo[25]=1 -> monitor_error=0. reset_n pulse mid-J_RD -> all outputs return to reset values.
